// File: rtl/onion_breathe_sequencer_if.sv
// onion_breathe_sequencer_if: Wishbone slave bus bundle for the breathe sequencer aperture
interface onion_breathe_sequencer_if #(parameter int ADDRWIDTH = 10);
  logic [ADDRWIDTH-1:0] WBs_ADR_i;
  logic                 WBs_CYC_i;
  logic                 WBs_STB_i;
  logic                 WBs_WE_i;
  logic [3:0]           WBs_BYTE_STB_i;
  logic [31:0]          WBs_DAT_i;
  logic [31:0]          WBs_DAT_o;
  logic                 WBs_ACK_o;
  modport master(output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
                 input WBs_DAT_o, WBs_ACK_o);
  modport slave(input WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
                output WBs_DAT_o, WBs_ACK_o);
endinterface

// File: rtl/onion_breathe_sequencer.sv
// onion_breathe_sequencer: Wishbone-programmed mask/hold step table driving breathe channel enables
module onion_breathe_sequencer #(
  parameter int          ADDRWIDTH          = 10,
  parameter int          NUM_STEPS          = 8,
  parameter int          HOLD_WIDTH         = 16,
  parameter logic [31:0] DEFAULT_READ_VALUE = 32'hDEF_FAB_AC,
  localparam int         SW                 = $clog2(NUM_STEPS)
) (
  input  logic                      WBs_CLK_i,
  input  logic                      WBs_RST_n_i,
  onion_breathe_sequencer_if.slave  wb,
  output logic [31:0]               SEQ_MASK_o,
  output logic [SW-1:0]             SEQ_STEP_o,
  output logic                      SEQ_BUSY_o,
  output logic                      SEQ_DONE_o
);
  localparam int AW = ADDRWIDTH - 2;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state;
  logic [31:0]           mask_tab [NUM_STEPS];
  logic [HOLD_WIDTH-1:0] hold_tab [NUM_STEPS];
  logic                  loop, sticky;
  logic [3:0]            last_step;
  logic [15:0]           prescale, pcnt;
  logic [HOLD_WIDTH-1:0] hold;
  logic [AW-1:0]         wa;
  logic [AW-5:0]         wh;
  logic [SW-1:0]         idx, nxt;
  logic [31:0]           rdata, cfg, nv;
  logic                  acc, wr, in_tab, start, stop, tick, last, load, unused_ok;
  function automatic logic [31:0] merge(input logic [31:0] o, n, input logic [3:0] b);
    return {b[3] ? n[31:24] : o[31:24], b[2] ? n[23:16] : o[23:16],
            b[1] ? n[15:8] : o[15:8], b[0] ? n[7:0] : o[7:0]};
  endfunction
  assign unused_ok = ^wb.WBs_ADR_i[1:0];
  assign wa     = wb.WBs_ADR_i[ADDRWIDTH-1:2];
  assign wh     = wa[AW-1:4];
  assign idx    = wa[SW-1:0];
  assign in_tab = {1'b0, wa[3:0]} < 5'(NUM_STEPS);
  assign acc    = wb.WBs_CYC_i & wb.WBs_STB_i & ~wb.WBs_ACK_o;
  assign wr     = acc & wb.WBs_WE_i;
  assign start  = wr && wa == AW'(0) && wb.WBs_BYTE_STB_i[0] && wb.WBs_DAT_i[0];
  assign stop   = wr && wa == AW'(0) && wb.WBs_BYTE_STB_i[0] && wb.WBs_DAT_i[2];
  assign cfg    = {prescale, 12'b0, last_step};
  assign nv     = merge(wa == AW'(1) ? cfg : wh == (AW-4)'(1) ? mask_tab[idx] : 32'(hold_tab[idx]),
                        wb.WBs_DAT_i, wb.WBs_BYTE_STB_i);
  always_comb
    rdata = wa == AW'(0) ? {30'b0, loop, 1'b0} :
            wa == AW'(1) ? cfg :
            wa == AW'(2) ? {23'b0, sticky, 4'(SEQ_STEP_o), 3'b0, SEQ_BUSY_o} :
            (in_tab && wh == (AW-4)'(1)) ? mask_tab[idx] :
            (in_tab && wh == (AW-4)'(2)) ? 32'(hold_tab[idx]) : DEFAULT_READ_VALUE;
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i)
    if (!WBs_RST_n_i) begin
      wb.WBs_ACK_o <= 1'b0;
      wb.WBs_DAT_o <= '0;
      loop         <= 1'b0;
      last_step    <= '0;
      prescale     <= '0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        mask_tab[i] <= '0;
        hold_tab[i] <= '0;
      end
    end else begin
      wb.WBs_ACK_o <= acc;
      if (acc) wb.WBs_DAT_o <= rdata;
      if (wr && wa == AW'(0) && wb.WBs_BYTE_STB_i[0]) loop <= wb.WBs_DAT_i[1];
      if (wr && wa == AW'(1)) begin
        prescale  <= nv[31:16];
        last_step <= nv[3:0];
      end
      if (wr && in_tab && wh == (AW-4)'(1)) mask_tab[idx] <= nv;
      if (wr && in_tab && wh == (AW-4)'(2)) hold_tab[idx] <= HOLD_WIDTH'(nv);
    end
  // LAST_STEP is compared live so CONFIG edits reshape a running sequence
  assign tick = pcnt >= prescale;
  assign last = 4'(SEQ_STEP_o) == last_step || SEQ_STEP_o == SW'(NUM_STEPS - 1);
  assign load = (state == IDLE && start) ||
                (state == RUN && tick && hold == HOLD_WIDTH'(1) && (!last || loop));
  assign nxt  = (state == IDLE || last) ? '0 : SEQ_STEP_o + 1'b1;
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i)
    if (!WBs_RST_n_i) begin
      state      <= IDLE;
      SEQ_MASK_o <= '0;
      SEQ_STEP_o <= '0;
      SEQ_BUSY_o <= 1'b0;
      SEQ_DONE_o <= 1'b0;
      sticky     <= 1'b0;
      hold       <= '0;
      pcnt       <= '0;
    end else begin
      SEQ_DONE_o <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        SEQ_MASK_o <= '0;
        SEQ_STEP_o <= '0;
        SEQ_BUSY_o <= 1'b0;
      end else if (load) begin
        if (state == IDLE) sticky <= 1'b0;
        state      <= RUN;
        SEQ_BUSY_o <= 1'b1;
        SEQ_STEP_o <= nxt;
        SEQ_MASK_o <= mask_tab[nxt];
        hold       <= hold_tab[nxt] == '0 ? HOLD_WIDTH'(1) : hold_tab[nxt];
        pcnt       <= '0;
      end else if (state == RUN && tick && hold == HOLD_WIDTH'(1)) begin
        state      <= IDLE;
        SEQ_MASK_o <= '0;
        SEQ_STEP_o <= '0;
        SEQ_BUSY_o <= 1'b0;
        SEQ_DONE_o <= 1'b1;
        sticky     <= 1'b1;
      end else if (state == RUN) begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
        if (tick) hold <= hold - 1'b1;
      end
    end
endmodule

// File: tb/tb_onion_breathe_sequencer.sv
// tb_onion_breathe_sequencer: directed checks of register map, step timing, loop, stop and byte writes
module tb_onion_breathe_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] seq_mask;
  logic [2:0]  seq_step;
  logic        seq_busy, seq_done, seen_done;
  logic [31:0] rd;
  int          tests = 0;
  int          fails = 0;
  onion_breathe_sequencer_if #(.ADDRWIDTH(10)) bus ();
  onion_breathe_sequencer dut (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .wb(bus),
    .SEQ_MASK_o(seq_mask), .SEQ_STEP_o(seq_step), .SEQ_BUSY_o(seq_busy), .SEQ_DONE_o(seq_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_bus();
    bus.WBs_CYC_i = 1'b0;
    bus.WBs_STB_i = 1'b0;
    bus.WBs_WE_i  = 1'b0;
  endtask
  task automatic wbw(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    @(negedge clk);
    bus.WBs_ADR_i = a; bus.WBs_DAT_i = d; bus.WBs_BYTE_STB_i = be;
    bus.WBs_CYC_i = 1'b1; bus.WBs_STB_i = 1'b1; bus.WBs_WE_i = 1'b1;
    @(posedge clk); #1;
    chk("write_ack", 32'(bus.WBs_ACK_o), 32'd1);
    @(negedge clk);
    idle_bus();
  endtask
  task automatic wbr(input logic [9:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.WBs_ADR_i = a; bus.WBs_BYTE_STB_i = 4'h0;
    bus.WBs_CYC_i = 1'b1; bus.WBs_STB_i = 1'b1; bus.WBs_WE_i = 1'b0;
    @(posedge clk); #1;
    chk("read_ack", 32'(bus.WBs_ACK_o), 32'd1);
    d = bus.WBs_DAT_o;
    @(negedge clk);
    idle_bus();
  endtask
  initial begin
    idle_bus();
    bus.WBs_ADR_i = '0; bus.WBs_DAT_i = '0; bus.WBs_BYTE_STB_i = '0;
    #12;
    chk("rst_mask", seq_mask, 0);
    chk("rst_busy", 32'(seq_busy), 0);
    chk("rst_done", 32'(seq_done), 0);
    chk("rst_ack", 32'(bus.WBs_ACK_o), 0);
    #10 rst_n = 1'b1;
    wbr(10'h008, rd); chk("status_reset", rd, 32'h0);
    wbr(10'h100, rd); chk("default_read", rd, 32'hDEFFABAC);
    @(posedge clk); #1; chk("ack_one_cycle", 32'(bus.WBs_ACK_o), 0);
    // two-step one-shot at full rate
    wbw(10'h040, 32'h1); wbw(10'h044, 32'h6);
    wbw(10'h080, 32'd3); wbw(10'h084, 32'd2);
    wbw(10'h004, 32'h0000_0001);
    wbr(10'h004, rd); chk("config_rb", rd, 32'h0000_0001);
    wbw(10'h000, 32'h1);
    chk("start_busy", 32'(seq_busy), 1);
    chk("start_step", 32'(seq_step), 0);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("oneshot_mask_c%0d", c), seq_mask, c <= 3 ? 32'h1 : 32'h6);
      chk($sformatf("oneshot_done_c%0d", c), 32'(seq_done), 0);
      @(negedge clk);
    end
    chk("end_mask", seq_mask, 0);
    chk("end_busy", 32'(seq_busy), 0);
    chk("end_done_pulse", 32'(seq_done), 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(seq_done), 0);
    wbr(10'h008, rd); chk("status_sticky", rd, 32'h100);
    // prescaled looping run, then stop during step 1
    wbw(10'h004, 32'h0004_0001);
    wbw(10'h000, 32'h3);
    wbr(10'h000, rd); chk("ctrl_loop_rb", rd, 32'h2);
    wbr(10'h008, rd); chk("status_sticky_cleared", rd & 32'h100, 32'h0);
    wbw(10'h000, 32'h4);
    wbw(10'h000, 32'h3);
    seen_done = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      seen_done |= seq_done;
      if (c == 15) chk("loop_c15_mask", seq_mask, 32'h1);
      if (c == 16) chk("loop_c16_mask", seq_mask, 32'h6);
      if (c == 16) chk("loop_c16_step", 32'(seq_step), 1);
      if (c == 25) chk("loop_c25_mask", seq_mask, 32'h6);
      if (c == 26) chk("loop_c26_step", 32'(seq_step), 0);
      if (c == 26) chk("loop_c26_mask", seq_mask, 32'h1);
      if (c == 41) chk("loop_c41_step", 32'(seq_step), 1);
      if (c < 45) @(negedge clk);
    end
    chk("loop_no_done", 32'(seen_done), 0);
    chk("loop_still_busy", 32'(seq_busy), 1);
    wbw(10'h000, 32'h4);
    chk("stop_busy", 32'(seq_busy), 0);
    chk("stop_mask", seq_mask, 0);
    chk("stop_no_done", 32'(seq_done), 0);
    @(negedge clk);
    chk("stop_no_done_late", 32'(seq_done), 0);
    // zero hold still lasts one prescale period
    wbw(10'h080, 32'd0);
    wbw(10'h004, 32'h0002_0000);
    wbw(10'h000, 32'h1);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("hold0_mask_c%0d", c), seq_mask, 32'h1);
      @(negedge clk);
    end
    chk("hold0_end_mask", seq_mask, 0);
    chk("hold0_done", 32'(seq_done), 1);
    // byte-lane write
    wbw(10'h048, 32'hAABBCCDD, 4'b0010);
    wbr(10'h048, rd); chk("byte_write", rd, 32'h0000CC00);
    wbr(10'h084, rd); chk("hold1_rb", rd, 32'd2);
    // START and STOP together in idle
    wbw(10'h000, 32'h5);
    chk("startstop_busy", 32'(seq_busy), 0);
    chk("startstop_mask", seq_mask, 0);
    @(negedge clk);
    chk("startstop_busy_late", 32'(seq_busy), 0);
    // async reset mid-run
    wbw(10'h080, 32'd50);
    wbw(10'h000, 32'h1);
    chk("pre_reset_busy", 32'(seq_busy), 1);
    rst_n = 1'b0; #1;
    chk("async_rst_mask", seq_mask, 0);
    chk("async_rst_busy", 32'(seq_busy), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(seq_busy), 0);
    wbr(10'h040, rd); chk("post_rst_table", rd, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
